dm_cache: RTL

//   Direct-mapped, write-through, no-write-allocate word cache inserted between
//   a requester and the ram model. Upstream port mirrors the ram protocol
//   (addr/din/dout/re/we/ready) so it drops in transparently; downstream port

---
 rtl/dm_cache.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dm_cache.sv
// Direct-mapped write-through, no-write-allocate word cache; read hit 1 cycle, miss/write wait on mem_ready.
// ready drops for any request and stays low while a downstream transaction is open; DM_CACHE_STATS_EN adds hit/miss counters.
module dm_cache #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_din,
  input  logic [WORD_WIDTH-1:0] mem_dout,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic                  mem_ready
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                  state_q;
  logic [WORD_WIDTH-1:0]   dout_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [WORD_WIDTH-1:0]   mem_din_q;
  logic                    mem_re_q;
  logic                    mem_we_q;
  logic [LINES-1:0]        valid_q;
  logic [WORD_WIDTH-1:0]   data_q [LINES];
  logic [TAG_W-1:0]        tag_q  [LINES];

  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    wr_acc;
  logic                    fill;

  assign req_idx  = addr[INDEX_BITS-1:0];
  assign req_tag  = addr[ADDR_WIDTH-1:INDEX_BITS];
  // The outstanding miss address doubles as the fill index/tag.
  assign fill_idx = mem_addr_q[INDEX_BITS-1:0];
  assign fill_tag = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign wr_acc   = (state_q == IDLE) && we && !re;
  assign fill     = (state_q == RD_WAIT) && !mem_re_q && mem_ready;

  assign ready    = (state_q == IDLE) && !re && !we;
  assign dout     = dout_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dout_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (re) begin
            if (hit) begin
              dout_q <= data_q[req_idx];
            end else begin
              mem_addr_q <= addr;
              mem_re_q   <= 1'b1;
              state_q    <= RD_WAIT;
            end
          end else if (we) begin
            mem_addr_q <= addr;
            mem_din_q  <= din;
            mem_we_q   <= 1'b1;
            state_q    <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (fill) begin
            valid_q[fill_idx] <= 1'b1;
            dout_q            <= mem_dout;
            state_q           <= IDLE;
          end
        end
        WR_WAIT: begin
          if (!mem_we_q && mem_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[fill_idx] <= mem_dout;
      tag_q[fill_idx]  <= fill_tag;
    end else if (wr_acc && hit) begin
      data_q[req_idx] <= din;
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if ((state_q == IDLE) && re) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
